mod_accumulator: RTL and testbench

Registered modular accumulator. Each enabled cycle it adds iData to a running sum and reduces the result modulo iMod. The output is the register value. It serves as a phase/index generator (e.g. a modulo counter or address rotator) inside unary/stochastic compute datapaths.

---
 rtl/mod_accumulator.sv | 71 +++++++
 tb/tb_mod_accumulator.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mod_accumulator.sv
// Registered modular accumulator: acc <= (acc + iData) reduced once by iMod on each enabled edge.
// Optional registered wrap pulse oWrap is enabled by defining MOD_ACC_WRAP_OUT_EN.
module mod_accumulator #(
  parameter int BITWIDTH = 32
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iEn,
  input  logic                iClr,
  input  logic [BITWIDTH-1:0] iData,
  input  logic [BITWIDTH-1:0] iMod,
`ifdef MOD_ACC_WRAP_OUT_EN
  output logic                oWrap,
`endif
  output logic [BITWIDTH-1:0] oData
);

  // Returns {wrapped, next}; the carry of acc + data takes part in the compare.
  function automatic logic [BITWIDTH:0] mod_step(
    input logic [BITWIDTH-1:0] acc,
    input logic [BITWIDTH-1:0] data,
    input logic [BITWIDTH-1:0] modulus
  );
    logic [BITWIDTH:0] sum;
    logic [BITWIDTH-1:0] diff;
    sum  = {1'b0, acc} + {1'b0, data};
    diff = sum[BITWIDTH-1:0] - modulus;
    if (sum >= {1'b0, modulus}) begin
      mod_step = {1'b1, diff};
    end else begin
      mod_step = {1'b0, sum[BITWIDTH-1:0]};
    end
  endfunction

  logic [BITWIDTH-1:0] acc_q, acc_d;
  logic                wrap_q, wrap_d;
  logic [BITWIDTH:0]   step;

  always_comb begin
    step   = mod_step(acc_q, iData, iMod);
    acc_d  = acc_q;
    wrap_d = 1'b0;
    if (iClr) begin
      acc_d = '0;
    end else if (iEn) begin
      acc_d  = step[BITWIDTH-1:0];
      wrap_d = step[BITWIDTH];
    end
  end

  // Register stage: acc and wrap flag
  always_ff @(posedge iClk) begin
    if (iRst) begin
      acc_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      wrap_q <= wrap_d;
    end
  end

  assign oData = acc_q;

`ifdef MOD_ACC_WRAP_OUT_EN
  assign oWrap = wrap_q;
`else
  logic unused_wrap;
  assign unused_wrap = wrap_q;
`endif

endmodule

// File: tb/tb_mod_accumulator.sv
// Directed self-checking bench for mod_accumulator; also checks oWrap when MOD_ACC_WRAP_OUT_EN is defined.
module tb_mod_accumulator;

  logic        iClk;
  logic        iRst;
  logic        iEn;
  logic        iClr;
  logic [31:0] iData;
  logic [31:0] iMod;
  logic [31:0] oData;
`ifdef MOD_ACC_WRAP_OUT_EN
  logic        oWrap;
`endif

  int n_cmp;
  int n_err;

  mod_accumulator #(.BITWIDTH(32)) dut (
    .iClk  (iClk),
    .iRst  (iRst),
    .iEn   (iEn),
    .iClr  (iClr),
    .iData (iData),
    .iMod  (iMod),
`ifdef MOD_ACC_WRAP_OUT_EN
    .oWrap (oWrap),
`endif
    .oData (oData)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then check oData (and oWrap when present) 1 time unit later.
  task automatic step_chk(input string tag, input logic [31:0] exp_d, input logic exp_w);
    @(posedge iClk);
    #1;
    chk(tag, oData, exp_d);
`ifdef MOD_ACC_WRAP_OUT_EN
    chk({tag, "_wrap"}, {31'd0, oWrap}, {31'd0, exp_w});
`else
    if (exp_w === 1'bx) $display("note: unexpected x in %s", tag);
`endif
  endtask

  logic [31:0] seq_d [14];
  logic        seq_w [14];

  initial begin
    seq_d = '{32'd10, 32'd7, 32'd4, 32'd1, 32'd11, 32'd8, 32'd5,
              32'd2, 32'd12, 32'd9, 32'd6, 32'd3, 32'd0, 32'd10};
    seq_w = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
              1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    n_cmp = 0;
    n_err = 0;
    iRst  = 1'b1;
    iEn   = 1'b1;
    iClr  = 1'b0;
    iData = 32'd10;
    iMod  = 32'd13;

    step_chk("rst0", 32'd0, 1'b0);
    step_chk("rst1", 32'd0, 1'b0);
    iRst = 1'b0;

    for (int i = 0; i < 14; i++) step_chk($sformatf("seq%0d", i), seq_d[i], seq_w[i]);

    // Clear overrides enable
    iClr = 1'b1;
    for (int i = 0; i < 3; i++) step_chk($sformatf("clr%0d", i), 32'd0, 1'b0);
    iClr = 1'b0;
    step_chk("restart0", 32'd10, 1'b0);
    step_chk("restart1", 32'd7, 1'b1);
    step_chk("restart2", 32'd4, 1'b1);

    // Hold with garbage on the data inputs
    iEn   = 1'b0;
    iData = 32'hDEAD_BEEF;
    iMod  = 32'h0000_0005;
    for (int i = 0; i < 5; i++) step_chk($sformatf("hold%0d", i), 32'd4, 1'b0);
    iEn   = 1'b1;
    iData = 32'd10;
    iMod  = 32'd13;
    step_chk("reen", 32'd1, 1'b1);

    // iData = iMod - 1 counts down
    iClr = 1'b1;
    step_chk("clr_b", 32'd0, 1'b0);
    iClr  = 1'b0;
    iData = 32'd12;
    step_chk("dn0", 32'd12, 1'b0);
    step_chk("dn1", 32'd11, 1'b1);
    step_chk("dn2", 32'd10, 1'b1);
    iData = 32'd0;
    step_chk("zero0", 32'd10, 1'b0);
    step_chk("zero1", 32'd10, 1'b0);

    // iMod = 0 acts as plain 2^32 wrap
    iClr = 1'b1;
    step_chk("clr_c", 32'd0, 1'b0);
    iClr  = 1'b0;
    iData = 32'd1;
    step_chk("one", 32'd1, 1'b0);
    iMod  = 32'd0;
    iData = 32'hFFFF_FFFF;
    step_chk("mod0_wrap", 32'd0, 1'b1);

    // Full-width compare needs the carry bit
    iData = 32'hFFFF_FFFE;
    step_chk("mod0_load", 32'hFFFF_FFFE, 1'b1);
    iMod  = 32'hFFFF_FFFF;
    step_chk("fullw", 32'hFFFF_FFFD, 1'b1);

    // Reset mid-accumulation, then resume from 0
    iRst  = 1'b1;
    iData = 32'd10;
    iMod  = 32'd13;
    step_chk("rst_mid", 32'd0, 1'b0);
    iRst = 1'b0;
    step_chk("rst_resume0", 32'd10, 1'b0);
    step_chk("rst_resume1", 32'd7, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
